// File: rtl/yarp_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : yarp_data_mem
// Brief    : Data-memory responder for the yarp core's data port. Byte/half/
//            word stores with lane steering, registered word reads, and
//            alignment/range error reporting. Zero-fills the array after reset
//            before accepting traffic.
// Revision : 1.0 - initial release
// ============================================================================
module yarp_data_mem #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        data_mem_rd_valid_o,
  output logic        data_mem_err_o,
  output logic        data_mem_busy_o
);

  localparam logic [31:0]   c_SPAN_BYTES = 32'(DEPTH) << 2;
  localparam logic [AW-1:0] c_LAST_IDX   = AW'(DEPTH - 1);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_RSVD = 2'b10;
  localparam logic [1:0] c_SZ_WORD = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_fill_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_misalign;
  logic          w_err;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic          w_store;
  logic          w_load;

  // State register and fill counter; reset restarts the zero-fill at word 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_fill_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end
  end

  // Next-state: leave INIT once the last word has been cleared
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_fill_cnt == c_LAST_IDX) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  assign data_mem_busy_o = (r_state == ST_INIT);
  assign w_accept        = (r_state == ST_READY) && data_mem_req_i;

  // Address decode; offset wraps mod 2^32 so addresses below the base fall out of range
  always_comb begin
    w_offset   = data_mem_addr_i - BASE_ADDR;
    w_in_range = (w_offset < c_SPAN_BYTES);
    w_idx      = w_offset[AW+1:2];
    w_lane     = data_mem_addr_i[1:0];
    w_misalign = (data_mem_byte_en_i == c_SZ_RSVD)
               || ((data_mem_byte_en_i == c_SZ_HALF) && w_lane[0])
               || ((data_mem_byte_en_i == c_SZ_WORD) && (w_lane != 2'b00));
    w_err      = !w_in_range || w_misalign;
    w_store    = w_accept && data_mem_wr_i && !w_err;
    w_load     = w_accept && !data_mem_wr_i;
  end

  // Lane steering: replicate LSB-aligned store data and pick the byte strobes
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = data_mem_wr_data_i;
    case (data_mem_byte_en_i)
      c_SZ_BYTE: begin
        w_wstrb = 4'b0001 << w_lane;
        w_wdata = {4{data_mem_wr_data_i[7:0]}};
      end
      c_SZ_HALF: begin
        w_wstrb = 4'b0011 << w_lane;
        w_wdata = {2{data_mem_wr_data_i[15:0]}};
      end
      c_SZ_WORD: begin
        w_wstrb = 4'b1111;
        w_wdata = data_mem_wr_data_i;
      end
      default: begin
        w_wstrb = 4'b0000;
        w_wdata = data_mem_wr_data_i;
      end
    endcase
  end

  // Array writes: zero-fill during INIT, byte-strobed stores once READY
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == ST_INIT) begin
        r_mem[r_fill_cnt] <= 32'h0;
      end else if (w_store) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wstrb[b]) begin
            r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Response registers: one-cycle valid/err pulses, read data held between loads
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_mem_rd_data_o  <= 32'h0;
      data_mem_rd_valid_o <= 1'b0;
      data_mem_err_o      <= 1'b0;
    end else begin
      data_mem_rd_valid_o <= w_load;
      data_mem_err_o      <= w_accept && w_err;
      if (w_load) begin
        data_mem_rd_data_o <= w_err ? 32'h0 : r_mem[w_idx];
      end
    end
  end

endmodule
`default_nettype wire
